// File: rtl/network_queue_dequeue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : network_queue_dequeue_ctrl
// Brief    : Per-queue head/count tracking with next-pointer fetch on dequeue.
// Revision : 1.0 - initial release
// ============================================================================
module network_queue_dequeue_ctrl #(
    parameter int QUEUE_NUM = 8,
    parameter int QID_W     = 3,
    parameter int ADDR_W    = 9
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enq_wr,
    input  logic [QID_W-1:0]     iv_enq_queue_id,
    input  logic [ADDR_W-1:0]    iv_enq_pkt_id,
    output logic                 o_enq_overflow,
    input  logic                 i_deq_req,
    input  logic [QID_W-1:0]     iv_deq_queue_id,
    output logic                 o_deq_ready,
    output logic                 o_deq_valid,
    output logic [ADDR_W-1:0]    ov_deq_pkt_id,
    output logic                 o_deq_empty,
    output logic [QUEUE_NUM-1:0] ov_queue_empty,
    output logic                 o_queue_rd,
    output logic [ADDR_W-1:0]    ov_queue_raddr,
    input  logic [ADDR_W-1:0]    iv_queue_rdata,
    input  logic                 i_queue_rdata_valid
);

    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        READ_S = 2'd1,
        WAIT_S = 2'd2
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [ADDR_W-1:0]    r_head_q  [QUEUE_NUM];
    logic [ADDR_W-1:0]    w_head_d  [QUEUE_NUM];
    logic [CNT_W-1:0]     r_count_q [QUEUE_NUM];
    logic [CNT_W-1:0]     w_count_d [QUEUE_NUM];
    logic [QID_W-1:0]     r_fetch_qid_q, w_fetch_qid_d;
    logic                 r_ready_q,     w_ready_d;
    logic                 r_enq_ovf_q,   w_enq_ovf_d;
    logic                 r_deq_valid_q, w_deq_valid_d;
    logic [ADDR_W-1:0]    r_deq_pkt_q,   w_deq_pkt_d;
    logic                 r_deq_empty_q, w_deq_empty_d;
    logic [QUEUE_NUM-1:0] r_qempty_q,    w_qempty_d;
    logic                 r_rd_q,        w_rd_d;
    logic [ADDR_W-1:0]    r_raddr_q,     w_raddr_d;

    logic                 w_deq_fire;
    logic [CNT_W-1:0]     w_deq_cnt;
    logic [CNT_W-1:0]     w_enq_cnt;

    assign w_deq_fire = i_deq_req && r_ready_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_head_d      = r_head_q;
        w_count_d     = r_count_q;
        w_fetch_qid_d = r_fetch_qid_q;
        w_enq_ovf_d   = 1'b0;
        w_deq_valid_d = 1'b0;
        w_deq_pkt_d   = r_deq_pkt_q;
        w_deq_empty_d = 1'b0;
        w_rd_d        = 1'b0;
        w_raddr_d     = r_raddr_q;
        w_deq_cnt     = r_count_q[iv_deq_queue_id];
        w_enq_cnt     = '0;

        case (r_state_q)
            IDLE_S: begin
                if (w_deq_fire) begin
                    if (w_deq_cnt == '0) begin
                        w_deq_empty_d = 1'b1;
                    end else begin
                        w_deq_valid_d                = 1'b1;
                        w_deq_pkt_d                  = r_head_q[iv_deq_queue_id];
                        w_count_d[iv_deq_queue_id]   = w_deq_cnt - c_CNT_ONE;
                        if (w_deq_cnt != c_CNT_ONE) begin
                            w_rd_d        = 1'b1;
                            w_raddr_d     = r_head_q[iv_deq_queue_id];
                            w_fetch_qid_d = iv_deq_queue_id;
                            w_state_d     = READ_S;
                        end
                    end
                end
            end
            READ_S, WAIT_S: begin
                // Raddr stays put until the data returns; the RAM bypass compares against it.
                if (i_queue_rdata_valid) begin
                    w_head_d[r_fetch_qid_q] = iv_queue_rdata;
                    w_state_d               = IDLE_S;
                end else if (r_state_q == READ_S) begin
                    w_state_d = WAIT_S;
                end
            end
            default: w_state_d = IDLE_S;
        endcase

        // Enqueue sees the count after any same-cycle dequeue, so +1/-1 nets out.
        w_enq_cnt = w_count_d[iv_enq_queue_id];
        if (i_enq_wr) begin
            if (w_enq_cnt == c_CNT_MAX) begin
                w_enq_ovf_d = 1'b1;
            end else begin
                w_count_d[iv_enq_queue_id] = w_enq_cnt + c_CNT_ONE;
                if (w_enq_cnt == '0) begin
                    w_head_d[iv_enq_queue_id] = iv_enq_pkt_id;
                end
            end
        end

        w_ready_d = (w_state_d == IDLE_S);
    end

    for (genvar g = 0; g < QUEUE_NUM; g++) begin : g_empty
        assign w_qempty_d[g] = (r_count_q[g] == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q     <= IDLE_S;
            r_head_q      <= '{default: '0};
            r_count_q     <= '{default: '0};
            r_fetch_qid_q <= '0;
            r_ready_q     <= 1'b0;
            r_enq_ovf_q   <= 1'b0;
            r_deq_valid_q <= 1'b0;
            r_deq_pkt_q   <= '0;
            r_deq_empty_q <= 1'b0;
            r_qempty_q    <= '1;
            r_rd_q        <= 1'b0;
            r_raddr_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_head_q      <= w_head_d;
            r_count_q     <= w_count_d;
            r_fetch_qid_q <= w_fetch_qid_d;
            r_ready_q     <= w_ready_d;
            r_enq_ovf_q   <= w_enq_ovf_d;
            r_deq_valid_q <= w_deq_valid_d;
            r_deq_pkt_q   <= w_deq_pkt_d;
            r_deq_empty_q <= w_deq_empty_d;
            r_qempty_q    <= w_qempty_d;
            r_rd_q        <= w_rd_d;
            r_raddr_q     <= w_raddr_d;
        end
    end

    assign o_enq_overflow = r_enq_ovf_q;
    assign o_deq_ready    = r_ready_q;
    assign o_deq_valid    = r_deq_valid_q;
    assign ov_deq_pkt_id  = r_deq_pkt_q;
    assign o_deq_empty    = r_deq_empty_q;
    assign ov_queue_empty = r_qempty_q;
    assign o_queue_rd     = r_rd_q;
    assign ov_queue_raddr = r_raddr_q;

endmodule
`default_nettype wire

// File: tb/tb_network_queue_dequeue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_queue_dequeue_ctrl
// Brief    : Linked-list queue model with RAM responder for the dequeue control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_network_queue_dequeue_ctrl;

    localparam int QN   = 8;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enq_wr = 1'b0, deq_req = 1'b0;
    logic [2:0] enq_q = '0, deq_q = '0;
    logic [8:0] enq_pkt = '0;
    logic       enq_ovf, deq_ready, deq_valid, deq_empty, q_rd;
    logic [8:0] deq_pkt, q_raddr;
    logic [7:0] q_empty;
    logic [8:0] rdata = '0;
    logic       rdv = 1'b0;

    always #4 clk = ~clk;

    network_queue_dequeue_ctrl #(.QUEUE_NUM(8), .QID_W(3), .ADDR_W(9)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_enq_wr(enq_wr), .iv_enq_queue_id(enq_q), .iv_enq_pkt_id(enq_pkt),
        .o_enq_overflow(enq_ovf),
        .i_deq_req(deq_req), .iv_deq_queue_id(deq_q),
        .o_deq_ready(deq_ready), .o_deq_valid(deq_valid), .ov_deq_pkt_id(deq_pkt),
        .o_deq_empty(deq_empty), .ov_queue_empty(q_empty),
        .o_queue_rd(q_rd), .ov_queue_raddr(q_raddr),
        .iv_queue_rdata(rdata), .i_queue_rdata_valid(rdv)
    );

    // Model: each queue is a list of packet IDs; next_ptr is the RAM the enqueue side links.
    logic [8:0] mq [QN][$];
    logic [8:0] next_ptr [MAXC];
    bit         live [MAXC];
    int         live_cnt = 0;
    int         nid = 0;
    logic       m_busy = 1'b0;
    logic       e_ready = 1'b0, e_valid = 1'b0, e_empty = 1'b0, e_ovf = 1'b0, e_rd = 1'b0;
    logic [8:0] e_pkt = '0, e_raddr = '0;
    logic [7:0] e_qempty = '1;
    int         ram_lat = 3, ram_cnt = 0;
    logic [8:0] ram_addr = '0;
    int         n_vec = 0, n_bad = 0;

    typedef struct {
        logic       enq;
        logic [2:0] eq;
        logic [8:0] ep;
        logic       deq;
        logic [2:0] dq;
        logic       x_valid;
        logic [8:0] x_pkt;
        logic       x_empty;
        logic       x_rd;
        logic [8:0] x_raddr;
        logic       x_ready;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic enq, input int eq, input int ep, input logic deq,
                                input int dq, input logic v, input int pkt, input logic emp,
                                input logic rd, input int ra, input logic rdy);
        vec_t r;
        r.enq = enq; r.eq = 3'(eq); r.ep = 9'(ep); r.deq = deq; r.dq = 3'(dq);
        r.x_valid = v; r.x_pkt = 9'(pkt); r.x_empty = emp; r.x_rd = rd;
        r.x_raddr = 9'(ra); r.x_ready = rdy;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: RAM responder, model update, edge, compare every output.
    task automatic cycle();
        logic [7:0] emp;
        logic [8:0] p;
        logic       accept;
        rdv = 1'b0;
        if (ram_cnt > 0) begin
            ram_cnt--;
            if (ram_cnt == 0) begin
                rdv   = 1'b1;
                rdata = next_ptr[ram_addr];
            end
        end
        if (q_rd === 1'b1) begin
            ram_cnt  = ram_lat;
            ram_addr = q_raddr;
        end

        if (rst) begin
            for (int i = 0; i < QN; i++) mq[i].delete();
            for (int i = 0; i < MAXC; i++) live[i] = 1'b0;
            live_cnt = 0;
            m_busy = 1'b0; e_ready = 1'b0; e_valid = 1'b0; e_empty = 1'b0;
            e_ovf = 1'b0; e_rd = 1'b0; e_pkt = '0; e_raddr = '0; e_qempty = '1;
        end else begin
            for (int i = 0; i < QN; i++) emp[i] = (mq[i].size() == 0);
            accept  = deq_req && e_ready;
            e_valid = 1'b0; e_empty = 1'b0; e_rd = 1'b0; e_ovf = 1'b0;
            if (accept) begin
                if (mq[deq_q].size() == 0) begin
                    e_empty = 1'b1;
                end else begin
                    e_valid = 1'b1;
                    e_pkt   = mq[deq_q].pop_front();
                    live[e_pkt] = 1'b0;
                    live_cnt--;
                    if (mq[deq_q].size() > 0) begin
                        e_rd = 1'b1; e_raddr = e_pkt; m_busy = 1'b1;
                    end
                end
            end else if (rdv && m_busy) begin
                m_busy = 1'b0;
            end
            if (enq_wr) begin
                if (mq[enq_q].size() >= MAXC) begin
                    e_ovf = 1'b1;
                end else begin
                    if (mq[enq_q].size() > 0) begin
                        p = mq[enq_q][$];
                        next_ptr[p] = enq_pkt;
                    end
                    mq[enq_q].push_back(enq_pkt);
                    live[enq_pkt] = 1'b1;
                    live_cnt++;
                end
            end
            e_ready  = !m_busy;
            e_qempty = emp;
        end

        @(posedge clk);
        #1;
        check("ready",  32'(deq_ready), 32'(e_ready));
        check("valid",  32'(deq_valid), 32'(e_valid));
        check("pkt_id", 32'(deq_pkt),   32'(e_pkt));
        check("empty",  32'(deq_empty), 32'(e_empty));
        check("ovf",    32'(enq_ovf),   32'(e_ovf));
        check("rd",     32'(q_rd),      32'(e_rd));
        check("raddr",  32'(q_raddr),   32'(e_raddr));
        check("qempty", 32'(q_empty),   32'(e_qempty));
    endtask

    task automatic idle_in();
        enq_wr = 1'b0; deq_req = 1'b0;
    endtask

    task automatic run_idle(input int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_enq(input int q, input int p);
        idle_in(); enq_wr = 1'b1; enq_q = 3'(q); enq_pkt = 9'(p);
        cycle();
    endtask

    task automatic do_deq(input int q);
        idle_in(); deq_req = 1'b1; deq_q = 3'(q);
        cycle();
    endtask

    initial begin
        tbl[0]  = mk(1, 2, 5,  0, 0, 0, 0,  0, 0, 0, 1);
        tbl[1]  = mk(1, 2, 9,  0, 0, 0, 0,  0, 0, 0, 1);
        tbl[2]  = mk(1, 2, 17, 0, 0, 0, 0,  0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0,  1, 2, 1, 5,  0, 1, 5, 0);
        tbl[4]  = mk(0, 0, 0,  0, 0, 0, 5,  0, 0, 5, 0);
        tbl[5]  = mk(0, 0, 0,  0, 0, 0, 5,  0, 0, 5, 0);
        tbl[6]  = mk(0, 0, 0,  0, 0, 0, 5,  0, 0, 5, 0);
        tbl[7]  = mk(0, 0, 0,  0, 0, 0, 5,  0, 0, 5, 1);
        tbl[8]  = mk(0, 0, 0,  1, 2, 1, 9,  0, 1, 9, 0);
        tbl[9]  = mk(0, 0, 0,  1, 2, 0, 9,  0, 0, 9, 0);
        tbl[10] = mk(0, 0, 0,  0, 0, 0, 9,  0, 0, 9, 0);
        tbl[11] = mk(0, 0, 0,  0, 0, 0, 9,  0, 0, 9, 0);
        tbl[12] = mk(0, 0, 0,  0, 0, 0, 9,  0, 0, 9, 1);
        tbl[13] = mk(0, 0, 0,  1, 2, 1, 17, 0, 0, 9, 1);
        tbl[14] = mk(0, 0, 0,  1, 0, 0, 17, 1, 0, 9, 1);
        tbl[15] = mk(1, 4, 7,  0, 0, 0, 17, 0, 0, 9, 1);
        tbl[16] = mk(1, 4, 30, 1, 4, 1, 7,  0, 0, 9, 1);
        tbl[17] = mk(0, 0, 0,  1, 4, 1, 30, 0, 0, 9, 1);
        tbl[18] = mk(0, 0, 0,  0, 0, 0, 30, 0, 0, 9, 1);

        // Reset held for three cycles, then release.
        rst = 1'b1;
        run_idle(3);
        rst = 1'b0;
        cycle();
        check("ready_after_release", 32'(deq_ready), 32'd1);

        // Directed vectors, RAM latency 3 (tbl[9] requests while busy and must be ignored).
        ram_lat = 3;
        for (int k = 0; k < 19; k++) begin
            enq_wr = tbl[k].enq; enq_q = tbl[k].eq; enq_pkt = tbl[k].ep;
            deq_req = tbl[k].deq; deq_q = tbl[k].dq;
            cycle();
            check($sformatf("tbl%0d_valid", k), 32'(deq_valid), 32'(tbl[k].x_valid));
            check($sformatf("tbl%0d_pkt", k),   32'(deq_pkt),   32'(tbl[k].x_pkt));
            check($sformatf("tbl%0d_empty", k), 32'(deq_empty), 32'(tbl[k].x_empty));
            check($sformatf("tbl%0d_rd", k),    32'(q_rd),      32'(tbl[k].x_rd));
            check($sformatf("tbl%0d_raddr", k), 32'(q_raddr),   32'(tbl[k].x_raddr));
            check($sformatf("tbl%0d_ready", k), 32'(deq_ready), 32'(tbl[k].x_ready));
        end
        check("qempty_all_after_tbl", 32'(q_empty), 32'hFF);

        // 2-cycle RAM latency with an enqueue to the fetched queue during WAIT_S.
        ram_lat = 2;
        do_enq(3, 40);
        do_enq(3, 41);
        do_deq(3);
        check("b_pkt40", 32'(deq_pkt), 32'd40);
        run_idle(1);
        do_enq(3, 42);
        check("b_ready_low_wait", 32'(deq_ready), 32'd0);
        run_idle(1);
        check("b_ready_back", 32'(deq_ready), 32'd1);
        do_deq(3);
        check("b_pkt41", 32'(deq_pkt), 32'd41);
        check("b_raddr41", 32'(q_raddr), 32'd41);
        run_idle(3);
        do_deq(3);
        check("b_pkt42", 32'(deq_pkt), 32'd42);
        check("b_no_rd_last", 32'(q_rd), 32'd0);
        run_idle(2);

        // Fill q1 to its maximum; extra enqueues overflow and leave the count alone.
        for (int i = 0; i < MAXC; i++) do_enq(1, i);
        do_enq(1, 3);
        check("ovf_first", 32'(enq_ovf), 32'd1);
        do_enq(1, 4);
        check("ovf_second", 32'(enq_ovf), 32'd1);
        run_idle(1);
        check("ovf_pulse_end", 32'(enq_ovf), 32'd0);

        // Reset during WAIT_S; the late rdata_valid must not touch the new head.
        ram_lat = 3;
        do_deq(1);
        check("r_pkt0", 32'(deq_pkt), 32'd0);
        run_idle(1);
        rst = 1'b1;
        run_idle(1);
        rst = 1'b0;
        run_idle(1);
        do_enq(1, 100);
        do_deq(1);
        check("r_head_after_reset", 32'(deq_pkt), 32'd100);
        check("r_no_rd_after_reset", 32'(q_rd), 32'd0);
        do_deq(1);
        check("r_empty_after_reset", 32'(deq_empty), 32'd1);
        run_idle(2);
        check("r_qempty_ff", 32'(q_empty), 32'hFF);

        // Randomized traffic against the list model.
        for (int n = 0; n < 1500; n++) begin
            idle_in();
            ram_lat = $urandom_range(2, 3);
            if ($urandom_range(0, 3) == 0 && live_cnt < 400) begin
                while (live[nid]) nid = (nid + 1) % MAXC;
                enq_wr  = 1'b1;
                enq_q   = 3'($urandom_range(0, QN - 1));
                enq_pkt = 9'(nid);
                nid     = (nid + 1) % MAXC;
            end
            if ($urandom_range(0, 9) < 6) begin
                deq_req = 1'b1;
                deq_q   = 3'($urandom_range(0, QN - 1));
            end
            cycle();
        end
        run_idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/network_queue_dequeue_ctrl.md
Name: network_queue_dequeue_ctrl

Overview:
- Read-side initiator for the network queue next-pointer RAM; the network output schedule calls it to dequeue packets.
- Keeps a head pointer and a packet count for each output queue. The counts are updated from enqueue notifications.
- On a dequeue it returns the head packet ID. It then fetches the next pointer from the queue RAM over the rd/raddr/rdata/rdata_valid interface and advances the head.

Parameters:
- QUEUE_NUM, 8, number of output queues.
- QID_W, 3, queue ID width; equals clog2(QUEUE_NUM).
- ADDR_W, 9, packet ID / queue RAM address width.

Ports:
- i_clk  in  1  125 MHz clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enq_wr  in  1  enqueue notification strobe (one packet per cycle).
- iv_enq_queue_id  in  QID_W  queue of the enqueued packet.
- iv_enq_pkt_id  in  ADDR_W  packet ID of the enqueued packet.
- o_enq_overflow  out  1  1-cycle pulse when an enqueue is dropped because the count is full.
- i_deq_req  in  1  dequeue request; accepted only while o_deq_ready=1.
- iv_deq_queue_id  in  QID_W  queue to dequeue.
- o_deq_ready  out  1  block is in IDLE and can accept a request.
- o_deq_valid  out  1  1-cycle pulse: ov_deq_pkt_id is valid.
- ov_deq_pkt_id  out  ADDR_W  dequeued packet ID.
- o_deq_empty  out  1  1-cycle pulse: the requested queue was empty.
- ov_queue_empty  out  QUEUE_NUM  per-queue empty bitmap (count==0).
- o_queue_rd  out  1  queue RAM read strobe, 1-cycle pulse.
- ov_queue_raddr  out  ADDR_W  queue RAM read address.
- iv_queue_rdata  in  ADDR_W  next pointer returned by the queue RAM.
- i_queue_rdata_valid  in  1  iv_queue_rdata is valid.

Behaviour:
- Reset values:
  - outputs: o_enq_overflow=0, o_deq_ready=0 during reset (1 from the first cycle after release), o_deq_valid=0, ov_deq_pkt_id=0, o_deq_empty=0, ov_queue_empty=all 1s, o_queue_rd=0, ov_queue_raddr=0.
  - state: all heads=0, all counts=0, FSM=IDLE_S.
- Count width is ADDR_W+1, giving a maximum of 2^ADDR_W.
- Enqueue, accepted in any state:
  - If count[q] is at maximum: drop the enqueue and pulse o_enq_overflow next cycle.
  - Otherwise count[q]+=1.
  - If the effective count was 0, head[q]<=iv_enq_pkt_id.
- FSM states IDLE_S, READ_S, WAIT_S.
- IDLE_S: o_deq_ready=1. On i_deq_req for queue q:
  - count==0: next cycle o_deq_empty=1; stay in IDLE_S.
  - count==1: next cycle o_deq_valid=1, ov_deq_pkt_id=head[q]; count<=0; stay in IDLE_S; no RAM read.
  - count>=2: next cycle o_deq_valid=1, ov_deq_pkt_id=head[q]; count-=1; o_queue_rd=1; ov_queue_raddr=head[q]; go to READ_S.
- READ_S / WAIT_S:
  - o_deq_ready=0; o_queue_rd=0.
  - ov_queue_raddr is held stable until i_queue_rdata_valid, because the RAM side compares it against write addresses for bypass.
  - READ_S goes to WAIT_S unless rdata_valid is already asserted.
  - On i_queue_rdata_valid (expected 2 or 3 cycles after o_queue_rd): head[q]<=iv_queue_rdata; go to IDLE_S; o_deq_ready returns the following cycle.
- Simultaneous enqueue and dequeue, same queue, same cycle:
  - Counts net out: +1 -1 gives no change.
  - When the dequeue empties the queue (count==1), the head takes iv_enq_pkt_id and no RAM read is issued.
  - A dequeue at count>=2 with a same-cycle enqueue: the head comes from RAM; the enqueue only increments the count.
- Enqueue to the queue being fetched during READ_S/WAIT_S: only the count changes. A head write from RAM data has priority; it cannot conflict because count>=1 throughout.
- i_deq_req while o_deq_ready=0 is ignored; no pulse is produced.
- Reset mid-operation: the FSM returns to IDLE_S, all counts are cleared, and a pending rdata_valid after reset is ignored.
- ov_queue_empty[i] = (count[i]==0), registered; it updates the cycle after the count changes.

Test Plan:
- Reset checks:
  - Assert i_rst for 3 cycles -> all outputs at their reset values, ov_queue_empty=8'hFF.
  - Release -> o_deq_ready=1 on the next cycle.
- Enqueue pkts 5, 9, 17 to q2; RAM model returns next[5]=9, next[9]=17 with 3-cycle latency; dequeue q2 three times ->
  - pkt IDs 5, 9, 17 in order;
  - o_queue_rd with raddr 5, then 9; no read on the third dequeue;
  - ov_queue_empty[2] returns to 1.
- Dequeue empty q0 -> o_deq_empty pulse for 1 cycle, o_deq_valid=0, o_queue_rd=0.
- q4 holds pkt 7; in the same cycle dequeue q4 and enqueue pkt 30 to q4 ->
  - pkt 7 returned, count stays 1, no RAM read;
  - next dequeue returns 30.
- RAM model with 2-cycle latency plus an enqueue to the same queue during WAIT_S -> head is correct, count is correct, o_deq_ready is low until valid+1.
- Enqueue 512 pkts to q1, then one more -> o_enq_overflow pulse and count stays 512.
- Assert reset during WAIT_S -> FSM returns to IDLE_S and counts clear.
